// File: rtl/core18_pkg.sv
// rtl/core18_pkg.sv - shared widths and pause FSM encoding for the core18 pause/timer unit
package core18_pkg;

    localparam int DEF_TIMER_W    = 12;
    localparam int DEF_PRESCALE_W = 8;

    typedef enum logic [1:0] {
        PT_IDLE = 2'd0,
        PT_WAIT = 2'd1,
        PT_DONE = 2'd2
    } pt_state_e;

endpackage

// File: rtl/pause_timer_unit_if.sv
// rtl/pause_timer_unit_if.sv - decoder-side bundle for the TIMER opcode and PAUSE handshake
interface pause_timer_unit_if
    import core18_pkg::*;
#(
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int PRESCALE_W = DEF_PRESCALE_W
);
    logic                  load;
    logic [TIMER_W-1:0]    load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  auto_reload;
    logic                  pause_req;
    logic                  stall;
    logic                  pause_ack;
    logic                  zero;
    logic [TIMER_W-1:0]    count;
    logic                  expire;

    modport master (
        output load, load_val, prescale, auto_reload, pause_req,
        input  stall, pause_ack, zero, count, expire
    );

    modport slave (
        input  load, load_val, prescale, auto_reload, pause_req,
        output stall, pause_ack, zero, count, expire
    );
endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - prescaler producing one tick every prescale+1 clocks
module tick_divider #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt;

    // An exact compare: lowering prescale below cnt lets cnt run through overflow first.
    assign tick = (cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end
endmodule

// File: rtl/pause_timer_unit.sv
// rtl/pause_timer_unit.sv - TIMER down-counter with auto-reload and PAUSE stall/ack responder
module pause_timer_unit
    import core18_pkg::*;
#(
    parameter int TIMER_W    = DEF_TIMER_W,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pause_timer_unit_if.slave bus
);
    logic               tick;
    logic [TIMER_W-1:0] count_q, count_d, reload_q;
    logic               zero_q, zero_d, expire_q, expire_d;
    logic               stall, ack, released;
    pt_state_e          state_q, state_d;

    tick_divider #(.PRESCALE_W(PRESCALE_W)) u_tick_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.load),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    always_comb begin
        count_d  = count_q;
        zero_d   = zero_q;
        expire_d = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
            zero_d  = (bus.load_val == '0);
        end else if (tick && (count_q != '0)) begin
            if (count_q == TIMER_W'(1)) begin
                expire_d = 1'b1;
                if (bus.auto_reload) begin
                    count_d = reload_q;
                    zero_d  = (reload_q == '0);
                end else begin
                    count_d = '0;
                    zero_d  = 1'b1;
                end
            end else begin
                count_d = count_q - TIMER_W'(1);
                zero_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
            zero_q   <= 1'b1;
            expire_q <= 1'b0;
            state_q  <= PT_IDLE;
        end else begin
            count_q  <= count_d;
            zero_q   <= zero_d;
            expire_q <= expire_d;
            state_q  <= state_d;
            if (bus.load) begin
                reload_q <= bus.load_val;
            end
        end
    end

    // WAIT leaves on the edge that will set zero/expire, so ACK lands in the cycle they show.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        ack      = 1'b0;
        released = zero_q | expire_q;
        case (state_q)
            PT_IDLE: begin
                if (bus.pause_req) begin
                    if (released) begin
                        ack = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = PT_WAIT;
                    end
                end
            end
            PT_WAIT: begin
                stall = bus.pause_req;
                if (!bus.pause_req) begin
                    state_d = PT_IDLE;
                end else if (zero_d || expire_d) begin
                    state_d = PT_DONE;
                end
            end
            PT_DONE: begin
                ack     = bus.pause_req;
                state_d = PT_IDLE;
            end
            default: state_d = PT_IDLE;
        endcase
    end

    assign bus.stall     = stall;
    assign bus.pause_ack = ack & rst_n;
    assign bus.count     = count_q;
    assign bus.zero      = zero_q;
    assign bus.expire    = expire_q;
endmodule

// File: tb/tb_pause_timer_unit.sv
// tb/tb_pause_timer_unit.sv - self-checking bench for pause_timer_unit with behavioural model
module tb_pause_timer_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic ack_seen;

    pause_timer_unit_if #(.TIMER_W(12), .PRESCALE_W(8)) bus ();

    pause_timer_unit #(.TIMER_W(12), .PRESCALE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: the timer as plain integers, the pause as "waiting" / "ack owed" flags
    int m_count, m_reload, m_pre, m_cycle;
    bit m_expire, m_waiting, m_ack_due;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_reload  = 0;
        m_pre     = 0;
        m_expire  = 0;
        m_waiting = 0;
        m_ack_due = 0;
    endtask

    initial begin
        bit exp_stall, exp_ack, tick, new_exp, new_rel, rel_now;
        model_reset();
        forever begin
            @(negedge clk);
            m_cycle++;
            if (!rst_n) model_reset();
            rel_now = (m_count == 0) || m_expire;
            exp_stall = 0;
            exp_ack   = 0;
            if (rst_n) begin
                if (m_ack_due) begin
                    exp_ack = bus.pause_req;
                end else if (m_waiting) begin
                    exp_stall = bus.pause_req;
                end else if (bus.pause_req) begin
                    exp_ack   = rel_now;
                    exp_stall = !rel_now;
                end
            end
            chk("m_count",  32'(bus.count),  32'(m_count));
            chk("m_zero",   32'(bus.zero),   32'(m_count == 0));
            chk("m_expire", 32'(bus.expire), 32'(m_expire));
            chk("m_stall",  32'(bus.stall),  32'(exp_stall));
            chk("m_ack",    32'(bus.pause_ack), 32'(exp_ack));
            if (rst_n) begin
                tick    = (m_pre == int'(bus.prescale));
                new_exp = 0;
                if (bus.load) begin
                    m_count  = int'(bus.load_val);
                    m_reload = int'(bus.load_val);
                end else if (tick && m_count > 0) begin
                    if (m_count == 1) begin
                        new_exp = 1;
                        m_count = bus.auto_reload ? m_reload : 0;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
                m_pre    = (bus.load || tick) ? 0 : (m_pre + 1) % 256;
                new_rel  = (m_count == 0) || new_exp;
                m_expire = new_exp;
                if (m_ack_due) begin
                    m_ack_due = 0;
                end else if (m_waiting) begin
                    if (!bus.pause_req) begin
                        m_waiting = 0;
                    end else if (new_rel) begin
                        m_waiting = 0;
                        m_ack_due = 1;
                    end
                end else if (bus.pause_req && !rel_now) begin
                    m_waiting = 1;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.prescale = '0;
        bus.auto_reload = 1'b0;
        bus.pause_req = 1'b0;
        repeat (3) next_cycle();
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_zero",  32'(bus.zero),  32'd1);
        rst_n = 1'b1;

        // 1: count 8..1 under stall, release with zero+expire+ack together
        next_cycle();
        bus.load = 1'b1; bus.load_val = 12'd8;
        next_cycle();
        bus.load = 1'b0; bus.pause_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("t1_count", 32'(bus.count), 32'(8 - k));
                chk("t1_stall", 32'(bus.stall), 32'd1);
            end else begin
                chk("t1_done_count",  32'(bus.count), 32'd0);
                chk("t1_done_zero",   32'(bus.zero),  32'd1);
                chk("t1_done_expire", 32'(bus.expire), 32'd1);
                chk("t1_done_ack",    32'(bus.pause_ack), 32'd1);
                chk("t1_done_stall",  32'(bus.stall), 32'd0);
            end
        end
        next_cycle();
        bus.pause_req = 1'b0;

        // 2: prescale 3, load 2 -> steps every 4 clocks, expire on the 8th
        bus.prescale = 8'd3; bus.load = 1'b1; bus.load_val = 12'd2;
        next_cycle();
        bus.load = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("t2_count",  32'(bus.count), (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0);
            chk("t2_expire", 32'(bus.expire), 32'(k == 8));
            if (k < 8) next_cycle();
        end

        // 3: auto-reload 3 -> 3,2,1,3.. with expire every 3 clocks, zero never set
        next_cycle();
        bus.prescale = 8'd0; bus.auto_reload = 1'b1; bus.load = 1'b1; bus.load_val = 12'd3;
        next_cycle();
        bus.load = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            chk("t3_count",  32'(bus.count), 32'(3 - (k % 3)));
            chk("t3_expire", 32'(bus.expire), 32'((k > 0) && (k % 3 == 0)));
            chk("t3_zero",   32'(bus.zero), 32'd0);
            if (k < 9) next_cycle();
        end
        next_cycle();
        bus.pause_req = 1'b1;
        @(negedge clk);
        chk("t3_stall", 32'(bus.stall), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t3_ack",   32'(bus.pause_ack), 32'd1);
        chk("t3_count_reloaded", 32'(bus.count), 32'd3);
        next_cycle();
        bus.pause_req = 1'b0;

        // 4: already zero -> same-cycle ack, no stall
        bus.auto_reload = 1'b0; bus.load = 1'b1; bus.load_val = 12'd0;
        next_cycle();
        bus.load = 1'b0; bus.pause_req = 1'b1;
        @(negedge clk);
        chk("t4_ack",   32'(bus.pause_ack), 32'd1);
        chk("t4_stall", 32'(bus.stall), 32'd0);
        next_cycle();
        bus.pause_req = 1'b0;

        // 5: reload 5 inside WAIT extends; reload 0 ends the pause on the next edge
        bus.load = 1'b1; bus.load_val = 12'd10;
        next_cycle();
        bus.load = 1'b0; bus.pause_req = 1'b1;
        repeat (3) next_cycle();
        bus.load = 1'b1; bus.load_val = 12'd5;
        next_cycle();
        bus.load = 1'b0;
        @(negedge clk);
        chk("t5_count", 32'(bus.count), 32'd5);
        chk("t5_stall", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.load = 1'b1; bus.load_val = 12'd0;
        next_cycle();
        bus.load = 1'b0;
        @(negedge clk);
        chk("t5_ack",  32'(bus.pause_ack), 32'd1);
        chk("t5_zero", 32'(bus.zero), 32'd1);
        next_cycle();
        bus.pause_req = 1'b0;

        // 6: async reset mid-WAIT, then an aborted pause
        bus.load = 1'b1; bus.load_val = 12'd10;
        next_cycle();
        bus.load = 1'b0; bus.pause_req = 1'b1;
        repeat (2) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_stall", 32'(bus.stall), 32'd0);
        chk("t6_ack",   32'(bus.pause_ack), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_zero",  32'(bus.zero), 32'd1);
        bus.pause_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        bus.load = 1'b1; bus.load_val = 12'd6;
        next_cycle();
        bus.load = 1'b0; bus.pause_req = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("t6_wait_stall", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.pause_req = 1'b0;
        @(negedge clk);
        chk("t6_abort_stall", 32'(bus.stall), 32'd0);
        chk("t6_abort_ack",   32'(bus.pause_ack), 32'd0);
        repeat (10) next_cycle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ack_seen = bus.pause_ack;
            next_cycle();
            rst_n = ($urandom_range(0, 499) != 0);
            bus.load = ($urandom_range(0, 19) == 0);
            bus.load_val = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 20));
            if ($urandom_range(0, 99) == 0) bus.prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.auto_reload = ~bus.auto_reload;
            if (bus.pause_req) begin
                if (ack_seen || $urandom_range(0, 49) == 0) bus.pause_req = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.pause_req = 1'b1;
            end
        end
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
